// File: rtl/mem_bus_master_pkg.sv
// rtl/mem_bus_master_pkg.sv - shared bus-2 command codes, widths and master state type
package mem_bus_master_pkg;

  localparam int ADDR2_WIDTH       = 15;
  localparam int DATA_WIDTH        = 16;
  localparam int LINE_BEATS        = 8;
  localparam int LINE_WIDTH        = LINE_BEATS * DATA_WIDTH;
  localparam int TIMEOUT_CYCLES    = 512;
  localparam int CTR2_WIDTH        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CACHE_OFFSET_SIZE = $clog2(LINE_WIDTH / 8);

  // A floating C2 resolves to 2'b00 in two-state models; that code is one the
  // master never waits for, so a released bus can never look like a reply.
  localparam logic [1:0] C2_WRITE_LINE = 2'b00;
  localparam logic [1:0] C2_NOP        = 2'b01;
  localparam logic [1:0] C2_RESPONSE   = 2'b10;
  localparam logic [1:0] C2_READ_LINE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_BURST,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_bus_master_line_serdes.sv
// rtl/mem_bus_master_line_serdes.sv - line shift register with beat counter for burst serialise/collect
module mem_bus_master_line_serdes
  import mem_bus_master_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int BEATS  = LINE_BEATS
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      load,
  input  logic [BEATS*DATA_W-1:0]   load_line,
  input  logic                      shift,
  input  logic [DATA_W-1:0]         beat_in,
  output logic [DATA_W-1:0]         beat_out,
  output logic [BEATS*DATA_W-1:0]   line_next,
  output logic                      last_beat
);

  localparam int LINE_W = BEATS * DATA_W;
  localparam int HALF   = DATA_W / 2;
  localparam int BEAT_W = $clog2(BEATS);

  logic [LINE_W-1:0] line_q;
  logic [BEAT_W-1:0] beat_cnt;

  // Lowest line byte travels on the upper D2 lane, so each beat is byte-swapped both ways.
  always_comb begin
    beat_out  = {line_q[HALF-1:0], line_q[DATA_W-1:HALF]};
    line_next = {beat_in[HALF-1:0], beat_in[DATA_W-1:HALF], line_q[LINE_W-1:DATA_W]};
    last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  end

  // Load a whole line, or shift one beat out of the bottom and one in at the top.
  always_ff @(posedge clk) begin
    if (RESET) begin
      line_q   <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      line_q   <= load_line;
      beat_cnt <= '0;
    end else if (shift) begin
      line_q   <= line_next;
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - cache-side bus-2 master issuing READ_LINE/WRITE_LINE bursts
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR2_W = ADDR2_WIDTH,
  parameter int DATA_W  = DATA_WIDTH,
  parameter int BEATS   = LINE_BEATS,
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR2_W-1:0]      req_addr,
  input  logic [BEATS*DATA_W-1:0] req_wdata,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic [BEATS*DATA_W-1:0] resp_rdata,
  output logic [ADDR2_W-1:0]      A2,
  inout  wire  [DATA_W-1:0]       D2,
  inout  wire  [1:0]              C2
);

  localparam int CTR2_W = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [CTR2_W-1:0]       wait_cnt;
  logic                    err_q;
  logic                    c2_oe, d2_oe;
  logic [1:0]              c2_out;
  logic                    sd_load, sd_shift, sd_last;
  logic [DATA_W-1:0]       sd_beat_out;
  logic [BEATS*DATA_W-1:0] sd_line_next;
  logic                    wait_clr, wait_inc, wait_expired, timeout_hit, rdata_upd;

  mem_bus_master_line_serdes #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) u_serdes (
    .clk       (clk),
    .RESET     (RESET),
    .load      (sd_load),
    .load_line (req_wdata),
    .shift     (sd_shift),
    .beat_in   (D2),
    .beat_out  (sd_beat_out),
    .line_next (sd_line_next),
    .last_beat (sd_last)
  );

  assign C2 = c2_oe ? c2_out : 2'bzz;
  assign D2 = d2_oe ? sd_beat_out : {DATA_W{1'bz}};
  assign wait_expired = (wait_cnt == CTR2_W'(TIMEOUT - 1));

  // Next-state and bus ownership; C2 is only sampled in states that never drive it.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    c2_oe       = 1'b0;
    c2_out      = C2_NOP;
    d2_oe       = 1'b0;
    sd_load     = 1'b0;
    sd_shift    = 1'b0;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    timeout_hit = 1'b0;
    rdata_upd   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sd_load = 1'b1;
          state_d = req_write ? ST_WR_BURST : ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        c2_oe    = 1'b1;
        c2_out   = C2_READ_LINE;
        wait_clr = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (C2 == C2_RESPONSE) begin
          sd_shift = 1'b1;
          state_d  = ST_RD_BURST;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_RD_BURST: begin
        sd_shift = 1'b1;
        if (sd_last) begin
          rdata_upd = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_WR_BURST: begin
        c2_oe    = 1'b1;
        c2_out   = C2_WRITE_LINE;
        d2_oe    = 1'b1;
        sd_shift = 1'b1;
        if (sd_last) begin
          wait_clr = 1'b1;
          state_d  = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (C2 == C2_NOP) begin
          state_d = ST_DONE;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_d     = ST_DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched address, wait timer, error flag and read-line holding register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      A2         <= '0;
      wait_cnt   <= '0;
      err_q      <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (sd_load) A2 <= req_addr;
      if (wait_clr) wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + CTR2_W'(1);
      if (state_q != ST_DONE && state_d == ST_DONE) err_q <= timeout_hit;
      if (rdata_upd) resp_rdata <= sd_line_next;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - directed self-checking bench for mem_bus_master
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  logic         clk = 1'b0;
  logic         RESET = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [14:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_rdata;
  logic [14:0]  A2;
  wire  [15:0]  D2;
  wire  [1:0]   C2;

  logic         mem_c2_oe = 1'b0;
  logic [1:0]   mem_c2 = C2_NOP;
  logic         mem_d2_oe = 1'b0;
  logic [15:0]  mem_d2 = '0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_rdcmd = 0, n_wrcmd = 0, n_resp = 0, n_drive = 0, n_accept = 0;

  logic [15:0]  rd_beats [8];
  logic [15:0]  wr_beats [8];
  logic [127:0] line_a, line_b;
  int s_rd, s_wr, s_resp, s_drive, s_acc, cyc;

  assign C2 = mem_c2_oe ? mem_c2 : 2'bzz;
  assign D2 = mem_d2_oe ? mem_d2 : 16'hzzzz;

  mem_bus_master dut (
    .clk        (clk),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .A2         (A2),
    .D2         (D2),
    .C2         (C2)
  );

  always #5 clk = ~clk;

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    if (dut.c2_oe && C2 == C2_READ_LINE) n_rdcmd <= n_rdcmd + 1;
    if (dut.c2_oe && C2 == C2_WRITE_LINE) n_wrcmd <= n_wrcmd + 1;
    if (resp_valid) n_resp <= n_resp + 1;
    if (dut.c2_oe || dut.d2_oe) n_drive <= n_drive + 1;
    if (req_valid && req_ready) n_accept <= n_accept + 1;
  end

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wr, input logic [14:0] addr, input logic [127:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    check_vec("accept_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic mem_reply(input int delay);
    repeat (delay) tick();
    for (int b = 0; b < 8; b++) begin
      mem_c2_oe = 1'b1;
      mem_c2    = C2_RESPONSE;
      mem_d2_oe = 1'b1;
      mem_d2    = rd_beats[b];
      if (b == 0) check_vec("rd_turnaround", dut.c2_oe, 1'b0);
      tick();
    end
    mem_c2_oe = 1'b0;
    mem_d2_oe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_a = 128'h0800_0700_0600_0500_0400_0300_0200_0100;
    line_b = 128'h57A7_56A6_55A5_54A4_53A3_52A2_51A1_50A0;
    wr_beats = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, 16'h0A0B, 16'h0C0D, 16'h0E0F};

    // Reset state
    tick(); tick();
    check_vec("rst_ready", req_ready, 1'b1);
    check_vec("rst_resp_valid", resp_valid, 1'b0);
    check_vec("rst_resp_err", resp_err, 1'b0);
    check_vec("rst_rdata", resp_rdata, 128'h0);
    check_vec("rst_a2", A2, 15'h0);
    check_vec("rst_bus_oe", {dut.c2_oe, dut.d2_oe}, 2'b00);
    RESET = 1'b0;
    tick();

    // Read with reply after 100 cycles
    s_rd = n_rdcmd; s_resp = n_resp;
    start_req(1'b0, 15'h0123, 128'h0);
    check_vec("rd_cmd_c2", C2, C2_READ_LINE);
    check_vec("rd_cmd_a2", A2, 15'h0123);
    check_vec("rd_cmd_ready", req_ready, 1'b0);
    check_vec("rd_cmd_d2_oe", dut.d2_oe, 1'b0);
    tick();
    check_vec("rd_wait_c2_oe", dut.c2_oe, 1'b0);
    rd_beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    mem_reply(100);
    check_vec("rd_resp_valid", resp_valid, 1'b1);
    check_vec("rd_resp_err", resp_err, 1'b0);
    check_vec("rd_rdata_lo", resp_rdata[15:0], 16'h0100);
    check_vec("rd_rdata_hi", resp_rdata[127:112], 16'h0800);
    check_vec("rd_rdata", resp_rdata, line_a);
    tick();
    check_vec("rd_after_valid", resp_valid, 1'b0);
    check_vec("rd_after_ready", req_ready, 1'b1);
    check_vec("rd_cmd_cycles", n_rdcmd - s_rd, 1);
    check_vec("rd_resp_pulses", n_resp - s_resp, 1);

    // Write with NOP acknowledge after 185 cycles
    s_wr = n_wrcmd; s_resp = n_resp;
    start_req(1'b1, 15'h7FFF, 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    check_vec("wr_a2", A2, 15'h7FFF);
    for (int k = 0; k < 8; k++) begin
      check_vec($sformatf("wr_c2_%0d", k), C2, C2_WRITE_LINE);
      check_vec($sformatf("wr_d2_oe_%0d", k), dut.d2_oe, 1'b1);
      check_vec($sformatf("wr_d2_%0d", k), D2, wr_beats[k]);
      tick();
    end
    check_vec("wr_release", {dut.c2_oe, dut.d2_oe}, 2'b00);
    repeat (184) tick();
    check_vec("wr_no_early_resp", n_resp - s_resp, 0);
    mem_c2_oe = 1'b1; mem_c2 = C2_NOP;
    tick();
    mem_c2_oe = 1'b0;
    check_vec("wr_resp_valid", resp_valid, 1'b1);
    check_vec("wr_resp_err", resp_err, 1'b0);
    check_vec("wr_rdata_kept", resp_rdata, line_a);
    tick();
    check_vec("wr_cmd_cycles", n_wrcmd - s_wr, 8);
    check_vec("wr_resp_pulses", n_resp - s_resp, 1);

    // Read with no reply: timeout exactly 512 cycles after RD_WAIT entry
    start_req(1'b0, 15'h0055, 128'h0);
    tick();
    cyc = 0;
    while (!resp_valid && cyc < 600) begin
      tick();
      cyc++;
    end
    check_vec("to_cycles", cyc, 512);
    check_vec("to_resp_err", resp_err, 1'b1);
    check_vec("to_rdata_kept", resp_rdata, line_a);
    tick();
    check_vec("to_err_clears", resp_err, 1'b0);

    // Reset during beat 3 of a write burst
    s_resp = n_resp;
    start_req(1'b1, 15'h1111, 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100);
    repeat (3) tick();
    check_vec("rstmid_beat3", D2, 16'h6677);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_vec("rstmid_release", {dut.c2_oe, dut.d2_oe}, 2'b00);
    check_vec("rstmid_ready", req_ready, 1'b1);
    check_vec("rstmid_a2", A2, 15'h0);
    check_vec("rstmid_rdata", resp_rdata, 128'h0);
    repeat (3) tick();
    check_vec("rstmid_no_resp", n_resp - s_resp, 0);
    start_req(1'b0, 15'h0A5A, 128'h0);
    tick();
    for (int i = 0; i < 8; i++) rd_beats[i] = {8'hA0 + 8'(i), 8'h50 + 8'(i)};
    mem_reply(3);
    check_vec("rstmid_rd_valid", resp_valid, 1'b1);
    check_vec("rstmid_rd_rdata", resp_rdata, line_b);
    tick();

    // req_valid held high across two reads
    s_acc = n_accept;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0001;
    tick();
    req_addr = 15'h0002;
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("b2b_ready_low_%0d", i), req_ready, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) rd_beats[i] = 16'h1000 + 16'(i);
    mem_reply(0);
    check_vec("b2b_done_valid", resp_valid, 1'b1);
    check_vec("b2b_done_ready", req_ready, 1'b0);
    check_vec("b2b_one_accept", n_accept - s_acc, 1);
    tick();
    check_vec("b2b_idle_ready", req_ready, 1'b1);
    check_vec("b2b_a2_hold", A2, 15'h0001);
    tick();
    req_valid = 1'b0;
    check_vec("b2b_second_a2", A2, 15'h0002);
    check_vec("b2b_second_c2", C2, C2_READ_LINE);
    tick();
    mem_reply(1);
    check_vec("b2b_second_valid", resp_valid, 1'b1);
    check_vec("b2b_second_rdata", resp_rdata,
              128'h0710_0610_0510_0410_0310_0210_0110_0010);
    tick();
    check_vec("b2b_two_accepts", n_accept - s_acc, 2);

    // Idle for 50 cycles
    s_drive = n_drive; s_resp = n_resp;
    repeat (50) tick();
    check_vec("idle_no_drive", n_drive - s_drive, 0);
    check_vec("idle_no_resp", n_resp - s_resp, 0);
    check_vec("idle_ready", req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
